audio_fifo_arbiter: RTL and testbench

- Shares one 25-bit-word fifo between the left and right 24-bit audio sample producers, using round-robin write arbitration.
- Tags each word with its channel bit.
- Holds playback until a start watermark is reached, then streams words to one downstream consumer with a valid/ready handshake.
- Sits between the codec sample sources and the fifo instance. The fifo runs with DATA_WIDTH = SAMPLE_WIDTH+1.

---
 rtl/audio_fifo_pkg.sv | 26 ++
 rtl/fifo_level_tracker.sv | 52 +++++
 rtl/audio_fifo_arbiter.sv | 160 ++++++++++++++++
 tb/tb_audio_fifo_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fifo_pkg.sv
// audio_fifo_pkg
//   Shared types and constants for the audio fifo arbiter slice.
//   chan_t  : channel tag carried in the top bit of each fifo word.
//   state_t : playback FSM states.
//   TAG_BIT : position of the channel tag in a word at the default sample width.
package audio_fifo_pkg;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } chan_t;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam int SAMPLE_WIDTH_DEF = 24;
    localparam int TAG_BIT          = SAMPLE_WIDTH_DEF;

    // The tag always sits just above the sample, whatever the sample width.
    function automatic int tag_pos(input int sample_width);
        return sample_width;
    endfunction

endpackage

// File: rtl/fifo_level_tracker.sv
// fifo_level_tracker
//   Up/down occupancy counter that mirrors the external fifo count.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous, active-high reset
//     inc_i    in   a word is written this cycle
//     dec_i    in   a word is popped this cycle
//     level_o  out  tracked occupancy, 0..2**ADDR_WIDTH
module fifo_level_tracker #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [ADDR_WIDTH:0] level_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] level_q, level_d;

    // Simultaneous write and pop cancel out. The bounds guards keep the
    // counter from wrapping even if an upstream block misbehaves.
    always_comb begin
        level_d = level_q;
        if (inc_i && !dec_i && level_q != DEPTH) begin
            level_d = level_q + LVL_ONE;
        end else if (dec_i && !inc_i && level_q != '0) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(inc_i && !dec_i && level_q == DEPTH));
            assert (!(dec_i && !inc_i && level_q == '0));
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/audio_fifo_arbiter.sv
// audio_fifo_arbiter
//   Round-robin write arbiter for left/right audio samples into one shared
//   first-word-fall-through fifo, with a start watermark before playback and a
//   valid/ready stream to one consumer.
//   Build option: define ARB_STALL_STATS_EN to count blocked-request cycles on
//   stall_count; otherwise stall_count is a constant zero.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     req_l/data_l, req_r/data_r producer requests and samples
//     gnt_l, gnt_r               sample accepted this cycle
//     fifo_wr, fifo_w_data       fifo write strobe and {chan, sample}
//     fifo_full, fifo_empty      fifo status
//     fifo_rd, fifo_r_data       fifo pop strobe and head word
//     out_valid/out_ready        downstream handshake
//     out_data, out_chan         head sample and its channel tag
//     level                      tracked occupancy
//     underrun                   one-cycle pulse when streaming runs dry
//     stall_count                blocked-request cycle counter
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FILL   | collecting samples, output held off until START_LEVEL words
//   S_STREAM | presenting the fifo head to the consumer
module audio_fifo_arbiter
    import audio_fifo_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int ADDR_WIDTH   = 3,
    parameter int START_LEVEL  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_l,
    input  logic [SAMPLE_WIDTH-1:0] data_l,
    input  logic                    req_r,
    input  logic [SAMPLE_WIDTH-1:0] data_r,
    output logic                    gnt_l,
    output logic                    gnt_r,
    output logic                    fifo_wr,
    output logic [SAMPLE_WIDTH:0]   fifo_w_data,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    output logic                    fifo_rd,
    input  logic [SAMPLE_WIDTH:0]   fifo_r_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic                    out_chan,
    output logic [ADDR_WIDTH:0]     level,
    output logic                    underrun,
    output logic [15:0]             stall_count
);

    localparam int                  TAG_POS   = tag_pos(SAMPLE_WIDTH);
    localparam logic [ADDR_WIDTH:0] START_LVL = (ADDR_WIDTH+1)'(START_LEVEL);

    state_t state_q, state_d;
    chan_t  prio_q, prio_d;
    logic   underrun_q, underrun_d;

    // Write arbitration. Full blocks every grant, even when a pop in the same
    // cycle would make room; that keeps the grant path off the pop path.
    always_comb begin
        gnt_l  = 1'b0;
        gnt_r  = 1'b0;
        prio_d = prio_q;
        if (!reset && !fifo_full) begin
            if (req_l && (!req_r || prio_q == CH_L)) begin
                gnt_l = 1'b1;
            end else if (req_r) begin
                gnt_r = 1'b1;
            end
        end
        if (gnt_l) begin
            prio_d = CH_R;
        end else if (gnt_r) begin
            prio_d = CH_L;
        end
    end

    assign fifo_wr                        = gnt_l | gnt_r;
    assign fifo_w_data[TAG_POS]           = gnt_r;
    assign fifo_w_data[SAMPLE_WIDTH-1:0]  = gnt_r ? data_r : data_l;

    // Read side is a direct pass-through of the fall-through head.
    assign out_valid = !reset && (state_q == S_STREAM) && !fifo_empty;
    assign out_chan  = fifo_r_data[TAG_POS];
    assign out_data  = fifo_r_data[SAMPLE_WIDTH-1:0];
    assign fifo_rd   = out_valid & out_ready;

    fifo_level_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_level (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (fifo_wr),
        .dec_i   (fifo_rd),
        .level_o (level)
    );

    // Watermark compare uses the registered level, so streaming starts one
    // cycle after the level register reaches START_LEVEL. A write landing on
    // an empty fifo keeps streaming alive rather than bouncing through FILL.
    always_comb begin
        state_d    = state_q;
        underrun_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (level >= START_LVL) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (fifo_empty && !fifo_wr) begin
                    state_d    = S_FILL;
                    underrun_d = 1'b1;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FILL;
            prio_q     <= CH_L;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;

`ifdef ARB_STALL_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((req_l | req_r) && fifo_full && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_fifo_arbiter.sv
module tb_audio_fifo_arbiter;

    localparam int SW    = 24;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef ARB_STALL_STATS_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_l, req_r;
    logic [SW-1:0] data_l, data_r;
    logic          gnt_l, gnt_r;
    logic          fifo_wr, fifo_rd;
    logic [SW:0]   fifo_w_data;
    logic          fifo_full, fifo_empty;
    logic [SW:0]   fifo_r_data;
    logic          out_ready, out_valid;
    logic [SW-1:0] out_data;
    logic          out_chan;
    logic [AW:0]   level;
    logic          underrun;
    logic [15:0]   stall_count;

    always #5 clk = ~clk;

    audio_fifo_arbiter #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .START_LEVEL(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_l       (req_l),
        .data_l      (data_l),
        .req_r       (req_r),
        .data_r      (data_r),
        .gnt_l       (gnt_l),
        .gnt_r       (gnt_r),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .fifo_r_data (fifo_r_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .level       (level),
        .underrun    (underrun),
        .stall_count (stall_count)
    );

    // Behavioural first-word-fall-through fifo standing in for the real instance.
    logic [SW:0] mem [DEPTH];
    int          cnt = 0, wp = 0, rp = 0;
    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0; wp <= 0; rp <= 0;
        end else begin
            if (fifo_wr && cnt < DEPTH) begin
                mem[wp] <= fifo_w_data;
                wp      <= (wp + 1) % DEPTH;
            end
            if (fifo_rd && cnt > 0) rp <= (rp + 1) % DEPTH;
            cnt <= cnt + ((fifo_wr && cnt < DEPTH) ? 1 : 0) - ((fifo_rd && cnt > 0) ? 1 : 0);
        end
    end
    assign fifo_full   = (cnt == DEPTH);
    assign fifo_empty  = (cnt == 0);
    assign fifo_r_data = mem[rp];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 after the rising edge; checks happen 3 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rl, input logic rr, input logic rdy);
        req_l = rl; req_r = rr; out_ready = rdy;
        #2;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rl, rr, rdy;
        logic        egl, egr;
        logic [SW:0] ewd;
        int          elvl;
        logic        eov;
        logic        ech;
    } vec_t;

    vec_t tbl [14];
    int   pulses;

    initial begin
        localparam logic [SW-1:0] DA = 24'h00000A;
        localparam logic [SW-1:0] DB = 24'h00000B;
        localparam logic [SW:0]   WL = {1'b0, DA};
        localparam logic [SW:0]   WR = {1'b1, DB};

        //              rl   rr   rdy  gl   gr   wdata lvl ov   ch
        tbl[0]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, WL, 0, 1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, WR, 1, 1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, WL, 2, 1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, WR, 3, 1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, WL, 4, 1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, WR, 5, 1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, WL, 6, 1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, WR, 7, 1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, WL, 8, 1'b1,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, WL, 8, 1'b1,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0, WL, 8, 1'b1,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b1,1'b1,1'b0, WL, 7, 1'b1,1'b1};
        tbl[12] = '{1'b1,1'b1,1'b1,1'b0,1'b1, WR, 7, 1'b1,1'b0};
        tbl[13] = '{1'b1,1'b1,1'b1,1'b1,1'b0, WL, 7, 1'b1,1'b1};

        reset = 1'b1; req_l = 0; req_r = 0; out_ready = 0;
        data_l = 24'h000011; data_r = DB;
        tick(); tick();
        chk("reset_gnt_l", gnt_l, 0);
        chk("reset_out_valid", out_valid, 0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        chk("reset_level", level, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_stall", stall_count, 0);

        // Single left producer: a grant every cycle until the watermark.
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0);
            chk("l_only_gnt_l", gnt_l, 1);
            chk("l_only_gnt_r", gnt_r, 0);
            chk("l_only_wdata", fifo_w_data, 25'h0000011);
            chk("l_only_level", level, i);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("l_only_level4", level, 4);
        chk("l_only_ov_fill", out_valid, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("l_only_ov_stream", out_valid, 1);
        chk("l_only_out_data", out_data, 24'h000011);

        // Alternating fill, full blocking, then pop with grants resuming.
        data_l = DA;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rl, tbl[i].rr, tbl[i].rdy);
            chk($sformatf("tbl%0d_gnt_l", i), gnt_l, tbl[i].egl);
            chk($sformatf("tbl%0d_gnt_r", i), gnt_r, tbl[i].egr);
            if (tbl[i].egl | tbl[i].egr)
                chk($sformatf("tbl%0d_wdata", i), fifo_w_data, tbl[i].ewd);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].elvl);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].eov);
            if (tbl[i].eov)
                chk($sformatf("tbl%0d_out_chan", i), out_chan, tbl[i].ech);
            tick();
        end

        // Drain with no producers: exactly one underrun pulse.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (underrun) begin
                pulses++;
                chk("underrun_ov", out_valid, 0);
            end
            tick();
        end
        chk("underrun_pulses", pulses, 1);
        drive(1'b0, 1'b0, 1'b1);
        chk("drained_level", level, 0);

        // Three writes stay in FILL; the fourth re-enters STREAM.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            chk("refill_gnt", gnt_l, 1);
            chk("refill_ov", out_valid, 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1);
        chk("refill_level4", level, 4);
        chk("refill_ov_fill", out_valid, 0);
        tick();
        drive(1'b0, 1'b0, 1'b1);
        chk("refill_ov_stream", out_valid, 1);

        // Mid-stream reset with five words stored.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("pre_reset_level", level, 5);
        chk("pre_reset_ov", out_valid, 1);
        tick();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        chk("in_reset_gnt_l", gnt_l, 0);
        chk("in_reset_wr", fifo_wr, 0);
        chk("in_reset_ov", out_valid, 0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        chk("post_reset_level", level, 0);
        chk("post_reset_ov", out_valid, 0);
        chk("post_reset_prio", gnt_l, 1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("post_reset_fill_state", out_valid, 0);

        // Stall counting while full.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        chk("stall_full", fifo_full, 1);
        chk("stall_start", stall_count, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            if (i == 9) chk("stall_no_gnt", gnt_l | gnt_r, 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("stall_count", stall_count, EXP_STALL);
        chk("stall_level", level, 8);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("stall_hold", stall_count, EXP_STALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
